dht_uart_reporter: RTL and testbench

Sequencer that turns each completed DHT11 40-bit frame into an ASCII report line and pushes it, one byte per accepted cycle, into the UART TX FIFO. It sits between the DHT11 receiver (frame + valid pulse) and the TX FIFO write port. It verifies the checksum and clamps the values the same way the FND display path does, so the FND and the UART always show the same numbers.

---
 rtl/dht_report_pkg.sv | 33 +++
 rtl/dht_frame_decode.sv | 47 ++++
 rtl/dht_uart_reporter.sv | 162 ++++++++++++++++
 tb/tb_dht_uart_reporter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dht_report_pkg.sv
// dht_report_pkg
// Shared types and constants for the DHT11 -> UART report path:
// sequencer state encoding, message lengths and the ASCII bytes used to
// build the report line.
`timescale 1ns/1ps
package dht_report_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [3:0] MSG_LEN_OK  = 4'd11;  // "Hxx% TxxC\r\n"
    localparam logic [3:0] MSG_LEN_ERR = 4'd5;   // "ERR\r\n"

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_H     = 8'h48;
    localparam logic [7:0] ASCII_T     = 8'h54;
    localparam logic [7:0] ASCII_PCT   = 8'h25;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_R     = 8'h52;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Decimal digit (0..9) to its ASCII character.
    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return ASCII_0 + {4'h0, d};
    endfunction

endpackage

// File: rtl/dht_frame_decode.sv
// dht_frame_decode
// Combinational decode of one DHT11 40-bit frame: checksum check, clamping
// of the integer humidity/temperature bytes and split into decimal digits.
// Shared with the FND display path so both show identical numbers.
// Ports:
//   frame_i  : {hum_int, hum_dec, temp_int, temp_dec, checksum}
//   chk_ok_o : sum of the four data bytes mod 256 equals the checksum byte
//   hum10_o  : tens digit of clamped humidity
//   hum1_o   : units digit of clamped humidity
//   tmp10_o  : tens digit of clamped temperature
//   tmp1_o   : units digit of clamped temperature
`timescale 1ns/1ps
module dht_frame_decode #(
    parameter int unsigned HUM_MAX  = 90,
    parameter int unsigned TEMP_MAX = 50
) (
    input  logic [39:0] frame_i,
    output logic        chk_ok_o,
    output logic [3:0]  hum10_o,
    output logic [3:0]  hum1_o,
    output logic [3:0]  tmp10_o,
    output logic [3:0]  tmp1_o
);

    localparam logic [7:0] HUM_MAX_B  = 8'(HUM_MAX);
    localparam logic [7:0] TEMP_MAX_B = 8'(TEMP_MAX);

    logic [9:0] sum;
    logic [7:0] hum_c;
    logic [7:0] tmp_c;

    always_comb begin
        sum = {2'b00, frame_i[39:32]} + {2'b00, frame_i[31:24]}
            + {2'b00, frame_i[23:16]} + {2'b00, frame_i[15:8]};
        chk_ok_o = ((sum % 10'd256) == {2'b00, frame_i[7:0]});

        hum_c = (frame_i[39:32] >= HUM_MAX_B)  ? HUM_MAX_B  : frame_i[39:32];
        tmp_c = (frame_i[23:16] >= TEMP_MAX_B) ? TEMP_MAX_B : frame_i[23:16];

        // Clamped values are at most 99, so the tens digit fits in 4 bits.
        hum10_o = 4'(hum_c / 8'd10);
        hum1_o  = 4'(hum_c % 8'd10);
        tmp10_o = 4'(tmp_c / 8'd10);
        tmp1_o  = 4'(tmp_c % 8'd10);
    end

endmodule

// File: rtl/dht_uart_reporter.sv
// dht_uart_reporter
// Turns each completed DHT11 frame into an ASCII report line and pushes it
// byte by byte into the UART TX FIFO. Frames arriving while a report is in
// progress are dropped and counted; checksum failures produce "ERR\r\n".
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_data       : DHT11 frame {hum_int, hum_dec, temp_int, temp_dec, checksum}
//   i_valid      : one-cycle pulse, i_data holds a new frame
//   i_fifo_full  : TX FIFO full, blocks pushes
//   o_push       : FIFO write strobe
//   o_tx_data    : byte written when o_push is high
//   o_busy       : report in progress
//   o_err_cnt    : saturating checksum-failure count
//   o_drop_cnt   : saturating count of frames ignored while busy
`timescale 1ns/1ps
module dht_uart_reporter
    import dht_report_pkg::*;
#(
    parameter int unsigned HUM_MAX  = 90,
    parameter int unsigned TEMP_MAX = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] i_data,
    input  logic        i_valid,
    input  logic        i_fifo_full,
    output logic        o_push,
    output logic [7:0]  o_tx_data,
    output logic        o_busy,
    output logic [7:0]  o_err_cnt,
    output logic [7:0]  o_drop_cnt
);

    state_t      state_q;
    logic [39:0] frame_q;
    logic [3:0]  idx_q;
    logic        err_q;
    logic [3:0]  h10_q, h1_q, t10_q, t1_q;
    logic        busy_q;
    logic [7:0]  err_cnt_q;
    logic [7:0]  drop_cnt_q;

    logic        chk_ok;
    logic [3:0]  h10, h1, t10, t1;
    logic [3:0]  last_idx;
    logic        push;
    logic [7:0]  tx_byte;

    dht_frame_decode #(
        .HUM_MAX  (HUM_MAX),
        .TEMP_MAX (TEMP_MAX)
    ) u_decode (
        .frame_i  (frame_q),
        .chk_ok_o (chk_ok),
        .hum10_o  (h10),
        .hum1_o   (h1),
        .tmp10_o  (t10),
        .tmp1_o   (t1)
    );

    assign last_idx = err_q ? (MSG_LEN_ERR - 4'd1) : (MSG_LEN_OK - 4'd1);

    // Push is combinational on the full flag so no write ever lands on a
    // full FIFO, even in the cycle the flag rises.
    assign push = (state_q == SEND) && !i_fifo_full;

    always_comb begin
        tx_byte = '0;
        if (state_q == SEND) begin
            if (err_q) begin
                case (idx_q)
                    4'd0:    tx_byte = ASCII_E;
                    4'd1:    tx_byte = ASCII_R;
                    4'd2:    tx_byte = ASCII_R;
                    4'd3:    tx_byte = ASCII_CR;
                    4'd4:    tx_byte = ASCII_LF;
                    default: tx_byte = '0;
                endcase
            end else begin
                case (idx_q)
                    4'd0:    tx_byte = ASCII_H;
                    4'd1:    tx_byte = digit_ascii(h10_q);
                    4'd2:    tx_byte = digit_ascii(h1_q);
                    4'd3:    tx_byte = ASCII_PCT;
                    4'd4:    tx_byte = ASCII_SPACE;
                    4'd5:    tx_byte = ASCII_T;
                    4'd6:    tx_byte = digit_ascii(t10_q);
                    4'd7:    tx_byte = digit_ascii(t1_q);
                    4'd8:    tx_byte = ASCII_C;
                    4'd9:    tx_byte = ASCII_CR;
                    4'd10:   tx_byte = ASCII_LF;
                    default: tx_byte = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            h10_q      <= '0;
            h1_q       <= '0;
            t10_q      <= '0;
            t1_q       <= '0;
            busy_q     <= 1'b0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            // A frame offered outside IDLE is lost, including on the final push.
            if (i_valid && (state_q != IDLE) && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end

            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        frame_q <= i_data;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    err_q <= !chk_ok;
                    h10_q <= h10;
                    h1_q  <= h1;
                    t10_q <= t10;
                    t1_q  <= t1;
                    if (!chk_ok && (err_cnt_q != 8'hFF)) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                    end
                    idx_q   <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    if (push) begin
                        if (idx_q == last_idx) begin
                            idx_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_push     = push;
    assign o_tx_data  = tx_byte;
    assign o_busy     = busy_q;
    assign o_err_cnt  = err_cnt_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_dht_uart_reporter.sv
`timescale 1ns/1ps
module tb_dht_uart_reporter;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] i_data;
    logic        i_valid;
    logic        i_fifo_full;
    logic        o_push;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic [7:0]  o_err_cnt;
    logic [7:0]  o_drop_cnt;

    dht_uart_reporter #(
        .HUM_MAX  (90),
        .TEMP_MAX (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_fifo_full (i_fifo_full),
        .o_push      (o_push),
        .o_tx_data   (o_tx_data),
        .o_busy      (o_busy),
        .o_err_cnt   (o_err_cnt),
        .o_drop_cnt  (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc_n = 0;
    int         npush = 0;
    int         first_push = -1;
    int         last_push = -1;
    logic [7:0] hold_exp = 8'h20;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected report bytes for a frame.
    function automatic void push_expected(input logic [39:0] d);
        logic [9:0] s;
        logic [7:0] h, t;
        s = d[39:32] + d[31:24] + d[23:16] + d[15:8];
        if (s[7:0] != d[7:0]) begin
            exp_q.push_back(8'h45); exp_q.push_back(8'h52); exp_q.push_back(8'h52);
            exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        end else begin
            h = (d[39:32] >= 8'd90) ? 8'd90 : d[39:32];
            t = (d[23:16] >= 8'd50) ? 8'd50 : d[23:16];
            exp_q.push_back(8'h48);
            exp_q.push_back(8'h30 + h / 8'd10);
            exp_q.push_back(8'h30 + h % 8'd10);
            exp_q.push_back(8'h25);
            exp_q.push_back(8'h20);
            exp_q.push_back(8'h54);
            exp_q.push_back(8'h30 + t / 8'd10);
            exp_q.push_back(8'h30 + t % 8'd10);
            exp_q.push_back(8'h43);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endfunction

    // One clock cycle: sample away from the edge, score any push, advance.
    task automatic cyc();
        logic [7:0] e;
        #2;
        if (i_fifo_full) begin
            chk("push_while_full", {31'd0, o_push}, 32'd0);
            chk("held_data", {24'd0, o_tx_data}, {24'd0, hold_exp});
        end
        if (o_push) begin
            npush++;
            if (first_push < 0) first_push = cyc_n;
            last_push = cyc_n;
            if (exp_q.size() == 0) begin
                chk("extra_push", {31'd0, o_push}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("tx_byte", {24'd0, o_tx_data}, {24'd0, e});
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // Send one frame and drain its report. stall_at >= 0 holds the FIFO full
    // for 3 cycles once that many bytes were pushed; ovr injects a frame
    // mid-report and another in the final-push cycle.
    task automatic run(input logic [39:0] d, input int n, input int stall_at, input bit ovr);
        int vc, nstall;
        bit o1, o2;
        nstall = 0; o1 = 0; o2 = 0;
        push_expected(d);
        npush = 0; first_push = -1;
        i_data = d; i_valid = 1'b1; vc = cyc_n;
        cyc();
        i_valid = 1'b0;
        chk("busy_after_valid", {31'd0, o_busy}, 32'd1);
        for (int k = 0; k < 100 && o_busy; k++) begin
            i_valid = 1'b0;
            i_fifo_full = (stall_at >= 0) && (npush == stall_at) && (nstall < 3);
            if (i_fifo_full) nstall++;
            if (ovr && !o1 && npush == 3) begin
                i_valid = 1'b1; i_data = {8'd10, 8'd0, 8'd10, 8'd0, 8'd20}; o1 = 1;
            end else if (ovr && !o2 && npush == n - 1) begin
                i_valid = 1'b1; i_data = {8'd11, 8'd0, 8'd12, 8'd0, 8'd23}; o2 = 1;
            end
            cyc();
        end
        i_valid = 1'b0;
        i_fifo_full = 1'b0;
        chk("busy_drained", {31'd0, o_busy}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("push_count", npush, n);
        chk("first_push_latency", first_push, vc + 2);
        chk("push_span", last_push - first_push, n - 1 + nstall);
        cyc(); cyc();
        chk("idle_no_push", {31'd0, o_push}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; i_data = '0; i_valid = 1'b0; i_fifo_full = 1'b0;
        #1;
        chk("rst_push", {31'd0, o_push}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_tx", {24'd0, o_tx_data}, 32'd0);
        chk("rst_err", {24'd0, o_err_cnt}, 32'd0);
        chk("rst_drop", {24'd0, o_drop_cnt}, 32'd0);
        rst = 1'b0;
        cyc();

        // Nominal report "H45% T23C"
        run({8'd45, 8'd0, 8'd23, 8'd0, 8'd68}, 11, -1, 0);
        chk("err_after_ok", {24'd0, o_err_cnt}, 32'd0);

        // Clamp above the limits, and just below/at them
        run({8'd95, 8'd0, 8'd60, 8'd0, 8'd155}, 11, -1, 0);
        run({8'd89, 8'd0, 8'd50, 8'd0, 8'd139}, 11, -1, 0);

        // Bad checksum
        run({8'd45, 8'd0, 8'd23, 8'd0, 8'd69}, 5, -1, 0);
        chk("err_cnt_1", {24'd0, o_err_cnt}, 32'd1);

        // Backpressure at index 4 (space byte)
        run({8'd45, 8'd7, 8'd23, 8'd3, 8'd78}, 11, 4, 0);

        // Overrun: mid-report and in the final-push cycle
        run({8'd45, 8'd0, 8'd23, 8'd0, 8'd68}, 11, -1, 1);
        chk("drop_cnt_2", {24'd0, o_drop_cnt}, 32'd2);
        chk("err_cnt_kept", {24'd0, o_err_cnt}, 32'd1);

        // Reset after the 5th push
        push_expected({8'd45, 8'd0, 8'd23, 8'd0, 8'd68});
        npush = 0;
        i_data = {8'd45, 8'd0, 8'd23, 8'd0, 8'd68}; i_valid = 1'b1;
        cyc();
        i_valid = 1'b0;
        for (int k = 0; k < 40 && npush < 5; k++) cyc();
        chk("pushes_before_rst", npush, 32'd5);
        rst = 1'b1;
        #1;
        chk("rst_mid_push", {31'd0, o_push}, 32'd0);
        chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_mid_err", {24'd0, o_err_cnt}, 32'd0);
        chk("rst_mid_drop", {24'd0, o_drop_cnt}, 32'd0);
        exp_q.delete();
        cyc();
        rst = 1'b0;
        cyc();
        run({8'd33, 8'd0, 8'd21, 8'd0, 8'd54}, 11, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
